// File: rtl/fifo_pkg.sv
// Shared types and constants for the matrix FIFO read path.
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 8;
   localparam int READER_MAX_LEN  = 8;
   localparam int READER_LEN_W    = $clog2(READER_MAX_LEN + 1);
   localparam int SKID_DEPTH      = 2;

   typedef logic [FIFO_DATA_WIDTH-1:0] data_t;
   typedef logic [READER_LEN_W-1:0]    rd_len_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } reader_state_e;

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry circular buffer that re-times FIFO read data toward the consumer.
module skid_buffer2
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_en,
   input  logic                  i_rd_en,
   input  logic [DATA_WIDTH-1:0] i_data_in,
   output logic [DATA_WIDTH-1:0] o_data_out,
   output logic [1:0]            o_occ
);

   logic [DATA_WIDTH-1:0] r_mem [0:SKID_DEPTH-1];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_occ;

   // The caller's credit check guarantees no write while full and no read while empty.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_data_in;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_rd_en) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({i_wr_en, i_rd_en})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_data_out = r_mem[r_rd_ptr];
   assign o_occ      = r_occ;

endmodule

// File: rtl/fifo_row_reader.sv
// Pops a commanded number of words from a 1-cycle-latency FIFO and streams
// them out through a skid buffer on a valid/ready interface.
module fifo_row_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int MAX_LEN    = READER_MAX_LEN,
   parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [LEN_W-1:0]      i_len,
   output logic                  o_busy,
   output logic                  o_done,
   input  logic                  i_fifo_empty,
   output logic                  o_fifo_pop,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic                  o_out_valid,
   input  logic                  i_out_ready
);

   reader_state_e    r_state;
   logic [LEN_W-1:0] r_pop_rem;
   logic [LEN_W-1:0] r_out_rem;
   logic             r_inflight;

   logic [1:0]       w_occ;
   logic [2:0]       w_pending;
   logic             w_fire;
   logic             w_pop;
   logic [LEN_W-1:0] w_len_sat;

   assign w_len_sat   = (i_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_len;
   assign o_out_valid = (w_occ != 2'd0);
   assign w_fire      = o_out_valid & i_out_ready;

   // Words already buffered plus the one still coming back from the FIFO must
   // fit in the skid buffer, counting the slot freed by a same-cycle fire.
   assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight};
   assign w_pop     = (r_state == RUN) && (r_pop_rem != '0) && !i_fifo_empty &&
                      (w_pending < (3'(SKID_DEPTH) + {2'b00, w_fire}));

   assign o_fifo_pop = w_pop;
   assign o_busy     = (r_state == RUN);
   assign o_done     = (r_state == DONE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_pop_rem  <= '0;
         r_out_rem  <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_pop;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_pop_rem <= w_len_sat;
                  r_out_rem <= w_len_sat;
                  r_state   <= (w_len_sat == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (w_pop) begin
                  r_pop_rem <= r_pop_rem - LEN_W'(1);
               end
               if (w_fire) begin
                  r_out_rem <= r_out_rem - LEN_W'(1);
                  if (r_out_rem == LEN_W'(1)) begin
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   skid_buffer2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_wr_en    (r_inflight),
      .i_rd_en    (w_fire),
      .i_data_in  (i_fifo_data),
      .o_data_out (o_out_data),
      .o_occ      (w_occ)
   );

endmodule

// File: tb/tb_fifo_row_reader.sv
// Bench for fifo_row_reader: directed scenarios plus randomized commands, with
// an upstream FIFO model and an in-order scoreboard of popped words.
module tb_fifo_row_reader;
   import fifo_pkg::*;

   logic    clk = 1'b0;
   logic    rst_n;
   logic    iStart;
   rd_len_t iLen;
   logic    iFifoEmpty;
   data_t   iFifoData;
   logic    iOutReady;
   logic    oBusy;
   logic    oDone;
   logic    oFifoPop;
   logic    oOutValid;
   data_t   oOutData;

   always #5 clk = ~clk;

   fifo_row_reader #(
      .DATA_WIDTH (FIFO_DATA_WIDTH),
      .MAX_LEN    (READER_MAX_LEN),
      .LEN_W      (READER_LEN_W)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (iStart),
      .i_len        (iLen),
      .o_busy       (oBusy),
      .o_done       (oDone),
      .i_fifo_empty (iFifoEmpty),
      .o_fifo_pop   (oFifoPop),
      .i_fifo_data  (iFifoData),
      .o_out_data   (oOutData),
      .o_out_valid  (oOutValid),
      .i_out_ready  (iOutReady)
   );

   // Inputs staged for the next cycle; stepCycle applies them just after the edge.
   logic    sStart;
   rd_len_t sLen;
   logic    sReady;
   logic    sForceEmpty;

   data_t   fifoMem [0:1023];
   int      fifoCount;
   int      fifoHead;
   logic    popPending;

   data_t   sbQ [$];
   int      popCycles [$];
   int      fireCycles [$];
   int      cycleNo;
   int      startCycle;
   int      cmdLen;
   int      popsThisCmd;
   int      firesThisCmd;
   int      lastFire;
   int      expDone;
   logic    inCmd;
   logic    prevValid;
   logic    prevReady;
   data_t   prevData;
   logic    pop1;
   logic    pop2;

   int      checks;
   int      errors;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic loadWord(input data_t d);
      fifoMem[fifoCount] = d;
      fifoCount++;
   endtask

   task automatic loadWords(input int n);
      for (int i = 0; i < n; i++) begin
         loadWord(data_t'($urandom));
      end
   endtask

   task automatic resetModel();
      sbQ.delete();
      popCycles.delete();
      fireCycles.delete();
      inCmd        = 1'b0;
      cmdLen       = 0;
      popsThisCmd  = 0;
      firesThisCmd = 0;
      lastFire     = -1;
      expDone      = -1;
      popPending   = 1'b0;
      prevValid    = 1'b0;
      prevReady    = 1'b0;
      prevData     = '0;
      pop1         = 1'b0;
      pop2         = 1'b0;
   endtask

   task automatic applyStimulus(input logic start, input int len, input logic ready, input logic forceEmpty);
      sStart      = start;
      sLen        = rd_len_t'(len);
      sReady      = ready;
      sForceEmpty = forceEmpty;
   endtask

   // One clock cycle: serve the FIFO, apply staged inputs, then check every
   // observable rule of the reader against the scoreboard.
   task automatic stepCycle();
      logic fire;
      logic expBusy;
      @(posedge clk);
      #1;
      if (popPending) begin
         iFifoData = fifoMem[fifoHead];
         fifoHead++;
         popPending = 1'b0;
      end
      iStart     = sStart;
      iLen       = sLen;
      iOutReady  = sReady;
      iFifoEmpty = sForceEmpty || (fifoHead >= fifoCount);
      #1;
      cycleNo++;

      expBusy = inCmd && (cmdLen > 0) && (cycleNo > startCycle) && ((lastFire < 0) || (cycleNo <= lastFire));
      checkOutput("busy", oBusy, expBusy);
      checkOutput("done", oDone, cycleNo == expDone);

      if (oFifoPop) begin
         checkOutput("popWhileEmpty", iFifoEmpty, 1'b0);
         sbQ.push_back(fifoMem[fifoHead]);
         popPending = 1'b1;
         popsThisCmd++;
         popCycles.push_back(cycleNo);
         checkOutput("popCount", popsThisCmd <= cmdLen, 1'b1);
      end

      if (pop2) checkOutput("popToValid", oOutValid, 1'b1);
      if (prevValid && !prevReady) begin
         checkOutput("holdValid", oOutValid, 1'b1);
         checkOutput("holdData", oOutData, prevData);
      end

      fire = oOutValid && iOutReady;
      if (fire) begin
         checkOutput("fireExpected", sbQ.size() != 0, 1'b1);
         if (sbQ.size() != 0) checkOutput("outData", oOutData, sbQ.pop_front());
         firesThisCmd++;
         fireCycles.push_back(cycleNo);
         if (firesThisCmd == cmdLen) begin
            lastFire = cycleNo;
            expDone  = cycleNo + 1;
         end
      end
      checkOutput("skidBound", sbQ.size() <= 2, 1'b1);

      if (cycleNo == expDone) begin
         checkOutput("popsAtDone", popsThisCmd, cmdLen);
         checkOutput("firesAtDone", firesThisCmd, cmdLen);
         inCmd = 1'b0;
      end else if (iStart && !inCmd) begin
         checkOutput("sbEmptyAtStart", sbQ.size(), 0);
         inCmd        = 1'b1;
         startCycle   = cycleNo;
         cmdLen       = (int'(iLen) > READER_MAX_LEN) ? READER_MAX_LEN : int'(iLen);
         popsThisCmd  = 0;
         firesThisCmd = 0;
         lastFire     = -1;
         expDone      = (cmdLen == 0) ? cycleNo + 1 : -1;
         popCycles.delete();
         fireCycles.delete();
      end

      pop2      = pop1;
      pop1      = oFifoPop;
      prevValid = oOutValid;
      prevReady = iOutReady;
      prevData  = oOutData;
   endtask

   task automatic runCommand(input int len, input int readyPct, input int emptyPct, input int budget);
      applyStimulus(1'b1, len, $urandom_range(0, 99) < readyPct, 1'b0);
      stepCycle();
      for (int k = 0; k < budget && inCmd; k++) begin
         applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 15),
                       $urandom_range(0, 99) < readyPct, $urandom_range(0, 99) < emptyPct);
         stepCycle();
      end
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      checkOutput("timeout", inCmd, 1'b0);
   endtask

   task automatic checkResetOutputs();
      checkOutput("rstBusy", oBusy, 1'b0);
      checkOutput("rstDone", oDone, 1'b0);
      checkOutput("rstPop", oFifoPop, 1'b0);
      checkOutput("rstValid", oOutValid, 1'b0);
      checkOutput("rstData", oOutData, 0);
   endtask

   initial begin
      int s;
      checks = 0;
      errors = 0;
      cycleNo = 0;
      startCycle = 0;
      fifoCount = 0;
      fifoHead = 0;
      iFifoData = '0;
      iStart = 1'b0;
      iLen = '0;
      iOutReady = 1'b1;
      iFifoEmpty = 1'b1;
      resetModel();
      applyStimulus(1'b0, 0, 1'b1, 1'b0);

      rst_n = 1'b0;
      #1;
      checkResetOutputs();
      stepCycle();
      stepCycle();
      rst_n = 1'b1;
      stepCycle();
      stepCycle();

      // Four words at full rate: pops at +1..+4, outputs at +3..+6, done at +7.
      for (int i = 0; i < 4; i++) loadWord(data_t'(8'hA0 + i));
      applyStimulus(1'b1, 4, 1'b1, 1'b0);
      stepCycle();
      s = cycleNo;
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) stepCycle();
      checkOutput("t2PopNum", popCycles.size(), 4);
      checkOutput("t2FireNum", fireCycles.size(), 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput("t2PopCycle", popCycles[i] - s, 1 + i);
         checkOutput("t2FireCycle", fireCycles[i] - s, 3 + i);
      end

      // Consumer stalls in cycles 3..6: only two pops, head word held.
      for (int i = 0; i < 4; i++) loadWord(data_t'(8'hB0 + i));
      for (int k = 0; k <= 12; k++) begin
         applyStimulus(k == 0, 4, !(k >= 3 && k <= 6), 1'b0);
         stepCycle();
         if (k == 5) checkOutput("t3Hold", oOutData, 8'hB0);
         if (k == 6) checkOutput("t3TwoPops", popsThisCmd, 2);
      end
      checkOutput("t3Complete", inCmd, 1'b0);

      // FIFO empty in cycles 2..5: pops at +1, +6, +7.
      for (int i = 0; i < 3; i++) loadWord(data_t'(8'hC0 + i));
      s = cycleNo + 1;
      for (int k = 0; k <= 12; k++) begin
         applyStimulus(k == 0, 3, 1'b1, k >= 2 && k <= 5);
         stepCycle();
      end
      checkOutput("t4PopNum", popCycles.size(), 3);
      checkOutput("t4Pop0", popCycles[0] - s, 1);
      checkOutput("t4Pop1", popCycles[1] - s, 6);
      checkOutput("t4Pop2", popCycles[2] - s, 7);
      checkOutput("t4Complete", inCmd, 1'b0);

      // Zero-length command.
      for (int k = 0; k <= 3; k++) begin
         applyStimulus(k == 0, 0, 1'b1, 1'b0);
         stepCycle();
         if (k == 1) checkOutput("t5Done", oDone, 1'b1);
         checkOutput("t5NoValid", oOutValid, 1'b0);
      end

      // Start re-asserted in RUN (+2) and in DONE (+6) must be ignored.
      for (int i = 0; i < 3; i++) loadWord(data_t'(8'hD0 + i));
      for (int k = 0; k <= 10; k++) begin
         applyStimulus(k == 0 || k == 2 || k == 6, 3, 1'b1, 1'b0);
         stepCycle();
         if (k == 6) checkOutput("t6DoneCycle", oDone, 1'b1);
      end
      checkOutput("t6Pops", popsThisCmd, 3);
      checkOutput("t6Idle", oBusy, 1'b0);

      // Reset in mid-command with two words buffered, then a normal command.
      for (int i = 0; i < 3; i++) loadWord(data_t'(8'hE0 + i));
      for (int k = 0; k <= 4; k++) begin
         applyStimulus(k == 0, 4, 1'b0, 1'b0);
         stepCycle();
      end
      checkOutput("t1Buffered", sbQ.size(), 2);
      checkOutput("t1ValidBefore", oOutValid, 1'b1);
      rst_n = 1'b0;
      #1;
      resetModel();
      checkResetOutputs();
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      stepCycle();
      rst_n = 1'b1;
      stepCycle();
      runCommand(1, 100, 0, 50);

      // Randomized commands, including lengths above the maximum.
      for (int n = 0; n < 30; n++) begin
         int len;
         len = $urandom_range(0, 15);
         loadWords((len > READER_MAX_LEN) ? READER_MAX_LEN : len);
         runCommand(len, 75, 20, 300);
         if ($urandom_range(0, 3) == 0) stepCycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
